// File: rtl/cdc_pkg.sv
// Shared definitions for the HF_CLK receive-side synchroniser bank.
package cdc_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int CFG_W_DEFAULT   = 38;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        APPLY     = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/cdc_sync_chain.sv
// Multi-bit flop chain for bringing asynchronous levels into HF_CLK.
module cdc_sync_chain
    import cdc_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = SYNC_STAGES_MIN
) (
    input  logic             HF_CLK,
    input  logic             NRST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the input through STAGES flops; every stage clears on reset.
    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/cdc_sync_bank.sv
// Receive-side CDC bank: reset, ENSAMP, levels, events and a toggle
// request/acknowledge capture of the configuration bus.
//
// Config FSM states:
//   state     | meaning
//   IDLE      | no request outstanding, or one just seen
//   WAIT_IDLE | request outstanding but held off while sampling is enabled
//   APPLY     | capture CFG_BUS, pulse CFG_UPD, toggle CFG_ACK
module cdc_sync_bank
    import cdc_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter int               N_LEVEL     = 8,
    parameter int               N_EVENT     = 4,
    parameter int               CFG_W       = CFG_W_DEFAULT,
    parameter logic [CFG_W-1:0] CFG_RST     = '0,
    parameter bit               CFG_GATE_EN = 1'b1
) (
    input  logic               HF_CLK,
    input  logic               NRST,
    output logic               NRST_sync,
    input  logic               ENSAMP,
    output logic               ENSAMP_sync,
    input  logic [N_LEVEL-1:0] LVL_IN,
    output logic [N_LEVEL-1:0] LVL_SYNC,
    input  logic [N_EVENT-1:0] EVT_IN,
    output logic [N_EVENT-1:0] EVT_PULSE,
    output logic [N_EVENT-1:0] EVT_FLAG,
    input  logic [N_EVENT-1:0] EVT_CLR,
    input  logic [CFG_W-1:0]   CFG_BUS,
    input  logic               CFG_REQ,
    output logic               CFG_ACK,
    output logic [CFG_W-1:0]   CFG_OUT,
    output logic               CFG_UPD,
    output logic               CFG_PEND
);

    // Out-of-range depths are clamped rather than producing a broken chain.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                            SYNC_STAGES;

    logic [STAGES-1:0]  rst_pipe;
    logic [N_EVENT-1:0] evt_s;
    logic [N_EVENT-1:0] evt_dly;
    logic               req_s;
    logic               outstanding;
    logic               gate_hold;
    cfg_state_e         state;

    // Reset synchroniser: asserts with NRST, releases after STAGES edges.
    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) rst_pipe <= '0;
        else       rst_pipe <= {rst_pipe[STAGES-2:0], 1'b1};
    end

    assign NRST_sync = rst_pipe[STAGES-1];

    cdc_sync_chain #(.WIDTH(1), .STAGES(STAGES)) u_ensamp_sync (
        .HF_CLK (HF_CLK),
        .NRST   (NRST),
        .d      (ENSAMP),
        .q      (ENSAMP_sync)
    );

    cdc_sync_chain #(.WIDTH(N_LEVEL), .STAGES(STAGES)) u_lvl_sync (
        .HF_CLK (HF_CLK),
        .NRST   (NRST),
        .d      (LVL_IN),
        .q      (LVL_SYNC)
    );

    cdc_sync_chain #(.WIDTH(N_EVENT), .STAGES(STAGES)) u_evt_sync (
        .HF_CLK (HF_CLK),
        .NRST   (NRST),
        .d      (EVT_IN),
        .q      (evt_s)
    );

    cdc_sync_chain #(.WIDTH(1), .STAGES(STAGES)) u_req_sync (
        .HF_CLK (HF_CLK),
        .NRST   (NRST),
        .d      (CFG_REQ),
        .q      (req_s)
    );

    // Delayed copy of the synchronised events for rising-edge detection.
    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) evt_dly <= '0;
        else       evt_dly <= evt_s;
    end

    assign EVT_PULSE = evt_s & ~evt_dly;

    // Sticky flags: a new pulse beats a simultaneous clear.
    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) EVT_FLAG <= '0;
        else       EVT_FLAG <= (EVT_FLAG & ~EVT_CLR) | EVT_PULSE;
    end

    assign outstanding = req_s ^ CFG_ACK;
    assign gate_hold   = CFG_GATE_EN && ENSAMP_sync;

    // Config handshake FSM with registered ACK/UPD/PEND and captured bus.
    always_ff @(posedge HF_CLK or negedge NRST) begin
        if (!NRST) begin
            state    <= IDLE;
            CFG_OUT  <= CFG_RST;
            CFG_UPD  <= 1'b0;
            CFG_ACK  <= 1'b0;
            CFG_PEND <= 1'b0;
        end else begin
            CFG_UPD <= 1'b0;
            case (state)
                IDLE: begin
                    if (outstanding) begin
                        if (gate_hold) begin
                            state    <= WAIT_IDLE;
                            CFG_PEND <= 1'b1;
                        end else begin
                            state <= APPLY;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // Withdrawal is checked first: applying a withdrawn
                    // request would re-open it by toggling ACK.
                    if (!outstanding) begin
                        state    <= IDLE;
                        CFG_PEND <= 1'b0;
                    end else if (!ENSAMP_sync) begin
                        state    <= APPLY;
                        CFG_PEND <= 1'b0;
                    end
                end
                APPLY: begin
                    CFG_OUT <= CFG_BUS;
                    CFG_UPD <= 1'b1;
                    CFG_ACK <= ~CFG_ACK;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
